// File: rtl/if_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests, response queue to ID.
// FETCH_PERF_EN adds perf_fetched/perf_bubbles. ADDR_W/INSTR_W fall back to 32 if config.vh is absent.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif

module if_fetch #(
    parameter int                 DEPTH    = 2,
    parameter logic [`ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                redirect,
    input  logic [`ADDR_W-1:0]  redirect_pc,
    output logic                imem_req,
    output logic [`ADDR_W-1:0]  imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rsp_valid,
    input  logic [`INSTR_W-1:0] imem_rsp_data,
    output logic                id_valid,
    output logic [`ADDR_W-1:0]  id_pc,
    output logic [`INSTR_W-1:0] id_instr,
    input  logic                id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    localparam int AW = `ADDR_W;
    localparam int IW = `INSTR_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] fetch_pc, rsp_pc;
    logic [CW-1:0] pend, drop, count;
    logic [PW-1:0] head, tail;
    logic [AW-1:0] pc_mem    [DEPTH];
    logic [IW-1:0] instr_mem [DEPTH];

    logic [CW+1:0] used;
    logic          accept, rsp_stale, push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Every request either in flight (live or stale) or queued holds one credit.
    assign used      = {2'b00, pend} + {2'b00, drop} + {2'b00, count};
    assign imem_req  = !areset && !redirect && (used < (CW+2)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign rsp_stale = imem_rsp_valid && (drop != '0);
    assign push      = imem_rsp_valid && (drop == '0) && !redirect;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready && !redirect;
    assign id_pc     = id_valid ? pc_mem[head]    : '0;
    assign id_instr  = id_valid ? instr_mem[head] : '0;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            pend     <= '0;
            drop     <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            // Live requests turn stale; a response arriving now retires one of them.
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            pend     <= '0;
            drop     <= drop + pend - CW'(imem_rsp_valid);
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + AW'(4);
            if (rsp_stale)
                drop <= drop - CW'(1);
            if (push) begin
                rsp_pc <= rsp_pc + AW'(4);
                tail   <= next_ptr(tail);
            end
            if (pop)
                head <= next_ptr(head);
            pend  <= pend + CW'(accept) - CW'(push);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= rsp_pc;
            instr_mem[tail] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (id_ready && !id_valid)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_if_fetch;

    localparam int DEPTH = 2;

    logic        clk;
    logic        areset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
    logic [31:0] m_fetched, m_bubbles;
`endif

    if_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .areset(areset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding requests (memory queue, tagged live/stale) and the ID-visible queue.
    typedef struct packed { logic [31:0] addr; logic live; } req_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    req_t        outq [$];
    ent_t        fifo [$];
    logic [31:0] m_fetch_pc;
    logic        rsp_en;
    int          n_pass, n_fail, n_total;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // One clock cycle: present memory response, compare outputs, advance the model.
    task automatic step();
        req_t r;
        logic exp_req, acc;
        r = '0;
        imem_rsp_valid = rsp_en && (outq.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data(outq[0].addr) : $urandom;
        #3;
        exp_req = !redirect && ((outq.size() + fifo.size()) < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, fifo.size() > 0});
        chk("id_pc",    id_pc,    (fifo.size() > 0) ? fifo[0].pc    : 32'h0);
        chk("id_instr", id_instr, (fifo.size() > 0) ? fifo[0].instr : 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubbles", perf_bubbles, m_bubbles);
        if (id_ready && fifo.size() == 0) m_bubbles++;
        if (id_ready && fifo.size() > 0 && !redirect) m_fetched++;
`endif
        acc = exp_req && imem_ready;
        if (imem_rsp_valid) r = outq.pop_front();
        if (redirect) begin
            fifo.delete();
            foreach (outq[i]) outq[i].live = 1'b0;
            m_fetch_pc = redirect_pc;
        end else begin
            if (fifo.size() > 0 && id_ready) void'(fifo.pop_front());
            if (imem_rsp_valid && r.live) fifo.push_back('{r.addr, mem_data(r.addr)});
            if (acc) begin
                outq.push_back('{m_fetch_pc, 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_ready = 1'b1;
        id_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        rsp_en = 1'b1;
        outq.delete();
        fifo.delete();
        m_fetch_pc = 32'h0;
`ifdef FETCH_PERF_EN
        m_fetched = 32'h0;
        m_bubbles = 32'h0;
`endif
        #2;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (id_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'b0, id_valid}, 32'h1);
    endtask

    initial begin
        logic [31:0] held;
        n_pass = 0; n_fail = 0; n_total = 0;
        areset = 1'b1;
        do_reset();

        // Stream: first accept in cycle 0, id_valid in cycle 2.
        imem_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
        step(); step();
        chk("t1_first_valid", {31'b0, id_valid}, 32'h1);
        chk("t1_first_pc", id_pc, 32'h0);
        chk("t1_first_instr", id_instr, 32'hA5A5_0000);
        repeat (20) step();

        // Backpressure: two requests fill the credits, then requests stop.
        do_reset();
        id_ready = 1'b0;
        repeat (4) step();
        chk("t2_req_stalled", {31'b0, imem_req}, 32'h0);
        id_ready = 1'b1;
        step();
        chk("t2_req_after_pop", {31'b0, imem_req}, 32'h1);
        chk("t2_addr_after_pop", imem_addr, 32'h8);
        repeat (6) step();

        // Redirect with two requests in flight.
        do_reset();
        id_ready = 1'b1; rsp_en = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0; rsp_en = 1'b1;
        wait_valid("t3_valid");
        chk("t3_pc", id_pc, 32'h100);
        repeat (6) step();

        // Redirect coinciding with a live response and a pop.
        do_reset();
        id_ready = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("t4_valid_cleared", {31'b0, id_valid}, 32'h0);
        wait_valid("t4_valid");
        chk("t4_pc", id_pc, 32'h200);
        repeat (4) step();

        // Memory stall: address and request held while the queue drains.
        do_reset();
        id_ready = 1'b1;
        repeat (6) step();
        imem_ready = 1'b0;
        step(); step();
        held = imem_addr;
        repeat (5) begin
            chk("t5_req_held", {31'b0, imem_req}, 32'h1);
            chk("t5_addr_held", imem_addr, held);
            step();
        end
        chk("t5_drained_valid", {31'b0, id_valid}, 32'h0);
        chk("t5_drained_instr", id_instr, 32'h0);
        imem_ready = 1'b1;
        repeat (4) step();

        // PC wrap at the top of the address space.
        do_reset();
        id_ready = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_valid("t6_valid0");
        chk("t6_pc0", id_pc, 32'hFFFF_FFFC);
        step();
        wait_valid("t6_valid1");
        chk("t6_pc1", id_pc, 32'h0);
        repeat (4) step();

        // Randomized traffic with variable memory latency, redirects and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            imem_ready  = ($urandom_range(0, 3) != 0);
            rsp_en      = ($urandom_range(0, 2) != 0);
            id_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00}
                                                      : $urandom;
            step();
        end
        redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
